// File: rtl/crypt_pkg.sv
// Shared definitions for the crypt_scheduler block: FSM state encoding,
// default frame/ciphertext widths, frame delimiter positions and the
// watchdog timer width helper.
package crypt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned FRAME_W_DEF = 32'd10;
  localparam int unsigned DATA_W_DEF  = 32'd8;
  localparam int unsigned START_BIT   = 32'd0;
  localparam int unsigned STOP_BIT    = 32'd9;

  // Bits needed for a counter that must hold values 0..cyc.
  function automatic int unsigned timer_w(input int unsigned cyc);
    return $clog2(cyc + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting bit found
// searching upward from ptr_i+1 with wrap-around. The pointer register is
// owned by the caller.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 32'd2,
  parameter int unsigned IDW     = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Rotating priority search starting just above the last winner.
  always_comb begin
    int unsigned cand;
    cand  = 32'd0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned off = 32'd1; off <= NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!any_o && req_i[cand[IDW-1:0]]) begin
        any_o                 = 1'b1;
        gnt_o[cand[IDW-1:0]]  = 1'b1;
        idx_o                 = cand[IDW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/crypt_scheduler.sv
// Round-robin scheduler sharing one encryptor between NUM_REQ requesters.
// Sequence per job: IDLE (arbitrate) -> ISSUE (start pulse) -> WAIT (done
// edge or watchdog) -> RESP (hold until consumer accepts).
// Optional feature macro: CRYPT_FRAME_CHECK_EN -- when defined, frames with a
// bad start/stop bit are rejected straight to RESP with rsp_frame_err set.
module crypt_scheduler
  import crypt_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 32'd2,
  parameter int unsigned FRAME_W     = FRAME_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 32'd15,
  localparam int unsigned IDW        = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       enc_enable,
  output logic [FRAME_W-1:0]         enc_data,
  input  logic [DATA_W-1:0]          enc_result,
  input  logic                       enc_done,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [IDW-1:0]             rsp_id,
  output logic                       rsp_timeout,
  output logic                       rsp_frame_err,
  input  logic                       rsp_ready,
  output logic                       busy
);

  localparam int unsigned TW = timer_w(TIMEOUT_CYC);

  state_e              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      id_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [TW-1:0]       timer_q;
  logic                enc_done_q;
  logic                enc_enable_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_timeout_q;
  logic                rsp_frame_err_q;
  logic                busy_q;

  logic [NUM_REQ-1:0]  gnt_s;
  logic [IDW-1:0]      gnt_idx_s;
  logic                gnt_any_s;
  logic [FRAME_W-1:0]  frame_sel_s;
  logic                done_edge_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (gnt_any_s)
  );

  // Select the granted requester's frame.
  always_comb begin
    frame_sel_s = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_s[i]) begin
        frame_sel_s = req_data[i*FRAME_W +: FRAME_W];
      end else begin
        frame_sel_s = frame_sel_s;
      end
    end
  end

  // Accept strobe only while arbitrating, and never while reset is held.
  always_comb begin
    if ((state_q == ST_IDLE) && rst_n) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // Only a fresh rising edge of done counts; stale levels are ignored.
  assign done_edge_s = enc_done & ~enc_done_q;

  // Main job FSM with all response/encryptor outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      ptr_q           <= IDW'(NUM_REQ - 32'd1);
      id_q            <= '0;
      frame_q         <= '0;
      timer_q         <= '0;
      enc_done_q      <= 1'b0;
      enc_enable_q    <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_frame_err_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      enc_done_q <= enc_done;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any_s) begin
            frame_q <= frame_sel_s;
            id_q    <= gnt_idx_s;
            ptr_q   <= gnt_idx_s;
            busy_q  <= 1'b1;
`ifdef CRYPT_FRAME_CHECK_EN
            if ((frame_sel_s[START_BIT] != 1'b0) || (frame_sel_s[STOP_BIT] != 1'b1)) begin
              state_q         <= ST_RESP;
              rsp_valid_q     <= 1'b1;
              rsp_data_q      <= '0;
              rsp_timeout_q   <= 1'b0;
              rsp_frame_err_q <= 1'b1;
            end else begin
              state_q      <= ST_ISSUE;
              enc_enable_q <= 1'b1;
            end
`else
            state_q      <= ST_ISSUE;
            enc_enable_q <= 1'b1;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          enc_enable_q <= 1'b0;
          timer_q      <= '0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge_s) begin
            rsp_data_q      <= enc_result;
            rsp_timeout_q   <= 1'b0;
            rsp_frame_err_q <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= ST_RESP;
          end else if (timer_q == TW'(TIMEOUT_CYC - 32'd1)) begin
            rsp_data_q      <= '0;
            rsp_timeout_q   <= 1'b1;
            rsp_frame_err_q <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= ST_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          enc_enable_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign enc_enable    = enc_enable_q;
  assign enc_data      = frame_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_id        = id_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_frame_err = rsp_frame_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crypt_scheduler.sv
// Directed, scoreboard-based bench for crypt_scheduler with a behavioural
// encryptor: result = frame[8:1] ^ 8'hFF, done pulses 4 cycles after enable.
module tb_crypt_scheduler;

  localparam int NUM_REQ = 2;
  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int IDW     = 1;

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [DATA_W-1:0] data;
    logic              to;
    logic              fe;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*FRAME_W-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       enc_enable;
  logic [FRAME_W-1:0]         enc_data;
  logic [DATA_W-1:0]          enc_result;
  logic                       enc_done;
  logic                       rsp_valid;
  logic [DATA_W-1:0]          rsp_data;
  logic [IDW-1:0]             rsp_id;
  logic                       rsp_timeout;
  logic                       rsp_frame_err;
  logic                       rsp_ready;
  logic                       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt = 0;
  int hs_cnt = 0;
  int rv_cnt = 0;
  exp_t exp_q[$];

  logic [3:0]        pipe_q = 4'b0000;
  logic [DATA_W-1:0] res_q  = 8'h00;
  logic              hang   = 1'b0;

  crypt_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .enc_enable    (enc_enable),
    .enc_data      (enc_data),
    .enc_result    (enc_result),
    .enc_done      (enc_done),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_timeout   (rsp_timeout),
    .rsp_frame_err (rsp_frame_err),
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Encryptor model: one-cycle done pulse 4 cycles after the enable cycle.
  always @(posedge clk) begin
    pipe_q <= {pipe_q[2:0], enc_enable};
    if (enc_enable) res_q <= enc_data[8:1] ^ 8'hFF;
  end
  assign enc_done   = pipe_q[3] & ~hang;
  assign enc_result = res_q;

  // Cycle, enable-pulse and handshake counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enc_enable) en_cnt <= en_cnt + 1;
    if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
    if (rsp_valid) rv_cnt <= rv_cnt + 1;
  end

  // Hard stop in case the sequence itself hangs.
  initial begin
    #100000;
    $display("FAIL global_timeout: observed no end, expected finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [FRAME_W-1:0] mk(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  function automatic exp_t mk_exp(input logic [IDW-1:0] id, input logic [7:0] d,
                                  input logic to, input logic fe);
    exp_t e;
    e.id = id; e.data = d; e.to = to; e.fe = fe;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no event, expected event within budget", tag);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"},     32'(req_ready),     32'd0);
    chk({tag, "_enc_enable"},    32'(enc_enable),    32'd0);
    chk({tag, "_enc_data"},      32'(enc_data),      32'd0);
    chk({tag, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    chk({tag, "_rsp_data"},      32'(rsp_data),      32'd0);
    chk({tag, "_rsp_id"},        32'(rsp_id),        32'd0);
    chk({tag, "_rsp_timeout"},   32'(rsp_timeout),   32'd0);
    chk({tag, "_rsp_frame_err"}, 32'(rsp_frame_err), 32'd0);
    chk({tag, "_busy"},          32'(busy),          32'd0);
  endtask

  task automatic wait_grant(input string tag, output logic [NUM_REQ-1:0] g, output int gc);
    g = '0;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
      @(negedge clk); #1;
    end
    gc = cyc;
    if (g == '0) bound_fail({tag, "_grant_wait"});
  endtask

  task automatic wait_rsp(input string tag, output int rc);
    exp_t e;
    logic seen;
    seen = 1'b0;
    #1;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    rc = cyc;
    if (!seen) begin
      bound_fail({tag, "_rsp_wait"});
    end else if (exp_q.size() == 0) begin
      bound_fail({tag, "_scoreboard_empty"});
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rsp_data"},      32'(rsp_data),      32'(e.data));
      chk({tag, "_rsp_id"},        32'(rsp_id),        32'(e.id));
      chk({tag, "_rsp_timeout"},   32'(rsp_timeout),   32'(e.to));
      chk({tag, "_rsp_frame_err"}, 32'(rsp_frame_err), 32'(e.fe));
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] exp_g[4];
    logic [FRAME_W-1:0] next_f[2];
    int gc, rc, e0, h0, v0, prev_gc, r;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    hang      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job: 10'h2AA carries data 8'h55, ciphertext 8'hAA
    rsp_ready = 1'b1;
    e0 = en_cnt;
    exp_q.push_back(mk_exp(1'b0, 8'hAA, 1'b0, 1'b0));
    req_data[9:0] = 10'h2AA;
    req_valid     = 2'b01;
    wait_grant("single", g, gc);
    chk("single_grant", 32'(g), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("single", rc);
    // rsp_valid rises on the 5th edge after the accepting edge
    chk("single_latency", 32'(rc - gc), 32'd6);
    @(negedge clk); #1;
    chk("single_enables", 32'(en_cnt - e0), 32'd1);
    chk("single_valid_drop", 32'(rsp_valid), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Backpressure: response held while the other requester waits
    rsp_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 8'h3C ^ 8'hFF, 1'b0, 1'b0));
    req_data[19:10] = mk(8'h3C);
    req_valid       = 2'b10;
    wait_grant("bp", g, gc);
    chk("bp_grant", 32'(g), 32'h2);
    @(negedge clk);
    req_valid     = 2'b01;
    req_data[9:0] = mk(8'hC5);
    wait_rsp("bp", rc);
    h0 = hs_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data",  32'(rsp_data),  32'hC3);
      chk("bp_hold_id",    32'(rsp_id),    32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 8'hC5 ^ 8'hFF, 1'b0, 1'b0));
    @(negedge clk); #1;
    chk("bp_one_handshake", 32'(hs_cnt - h0), 32'd1);
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    wait_grant("bp2", g, gc);
    chk("bp2_grant", 32'(g), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("bp2", rc);
    chk("bp2_latency", 32'(rc - gc), 32'd6);

    // Timeout: encryptor never completes, then a normal job follows
    @(negedge clk);
    hang = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 8'h00, 1'b1, 1'b0));
    req_data[19:10] = mk(8'h77);
    req_valid       = 2'b10;
    wait_grant("to", g, gc);
    chk("to_grant", 32'(g), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("to", rc);
    // ISSUE cycle plus 15 WAIT cycles before RESP
    chk("to_latency", 32'(rc - gc), 32'd17);
    @(negedge clk);
    hang = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 8'h81 ^ 8'hFF, 1'b0, 1'b0));
    req_data[9:0] = mk(8'h81);
    req_valid     = 2'b01;
    wait_grant("after_to", g, gc);
    chk("after_to_grant", 32'(g), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("after_to", rc);
    chk("after_to_latency", 32'(rc - gc), 32'd6);

    // Reset mid-WAIT: outputs clear at once, late done is ignored
    @(negedge clk);
    req_data[19:10] = mk(8'h5A);
    req_valid       = 2'b10;
    wait_grant("rst", g, gc);
    chk("rst_grant", 32'(g), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h0 = hs_cnt;
    v0 = rv_cnt;
    repeat (12) @(negedge clk);
    #1;
    chk("rst_no_rsp_valid", 32'(rv_cnt - v0), 32'd0);
    chk("rst_no_handshake", 32'(hs_cnt - h0), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);

    // Contention: both held valid, grants alternate starting at req0
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    next_f[0] = mk(8'h33);
    next_f[1] = mk(8'h44);
    exp_q.push_back(mk_exp(1'b0, 8'h11 ^ 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1'b1, 8'h22 ^ 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1'b0, 8'h33 ^ 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(1'b1, 8'h44 ^ 8'hFF, 1'b0, 1'b0));
    req_data  = {mk(8'h22), mk(8'h11)};
    req_valid = 2'b11;
    prev_gc   = 0;
    for (int j = 0; j < 4; j++) begin
      wait_grant("cont", g, gc);
      chk("cont_grant", 32'(g), 32'(exp_g[j]));
      if (j > 0) chk("cont_period", 32'(gc - prev_gc), 32'd7);
      prev_gc = gc;
      r = g[1] ? 1 : 0;
      @(negedge clk);
      if (j < 2) req_data[r*FRAME_W +: FRAME_W] = next_f[r];
      else       req_valid[r] = 1'b0;
      wait_rsp("cont", rc);
      chk("cont_latency", 32'(rc - gc), 32'd6);
    end

`ifdef CRYPT_FRAME_CHECK_EN
    // Frame check: bad start bit is rejected without starting the encryptor
    @(negedge clk);
    e0 = en_cnt;
    exp_q.push_back(mk_exp(1'b0, 8'h00, 1'b0, 1'b1));
    req_data[9:0] = 10'h001;
    req_valid     = 2'b01;
    wait_grant("fc", g, gc);
    chk("fc_grant", 32'(g), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("fc", rc);
    chk("fc_latency_le2", 32'((rc - gc) <= 2), 32'd1);
    @(negedge clk); #1;
    chk("fc_no_enable", 32'(en_cnt - e0), 32'd0);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
